// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with programmable
// almost-full/almost-empty thresholds, occupancy count, overflow/underflow
// pulses, synchronous flush and an optional first-word-fall-through read port.
//
// The occupancy count is kept in its own register. The pointers only address
// the storage array and are never compared to decide full/empty. Every status
// output is registered and is computed from the next-state count, so no
// combinational path runs from wr/rd to a flag.

module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,          // power of 2, >= 4
    parameter int AF_LEVEL = DEPTH - 2,   // 1..DEPTH
    parameter int AE_LEVEL = 2,           // 0..DEPTH-1
    parameter int FWFT     = 0            // 0: registered read, 1: fall-through
) (
    input  logic                       clk,
    input  logic                       rst,          // async, active-low
    input  logic                       clr,          // synchronous flush
    input  logic                       wr,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       rd,
    output logic [DATA_W-1:0]          data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              full_q;
    logic              empty_q;
    logic              almost_full_q;
    logic              almost_empty_q;
    logic              overflow_q;
    logic              underflow_q;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic              rd_acc;
    logic              wr_acc;
    logic [CNT_W-1:0]  count_nxt;
    logic              overflow_nxt;
    logic              underflow_nxt;

    // Accept decisions and pulse conditions, all from the registered flags.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        rd_acc        = 1'b0;
        wr_acc        = 1'b0;
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        if (!clr) begin
            rd_acc        = rd && !empty_q;
            // A simultaneous pop frees a slot, so a write at full still lands.
            wr_acc        = wr && (!full_q || rd_acc);
            overflow_nxt  = wr && full_q && !rd;
            underflow_nxt = rd && empty_q;
        end
    end

    // Occupancy: +1 on write only, -1 on read only, zero on flush.
    always_comb begin
        count_nxt = count_q;
        if (clr) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count_q - CNT_W'(1);
        end
    end

    // Pointer, count and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
                if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q        <= count_nxt;
            full_q         <= (count_nxt == CNT_FULL);
            empty_q        <= (count_nxt == '0);
            almost_full_q  <= (count_nxt >= CNT_AF);
            almost_empty_q <= (count_nxt <= CNT_AE);
            overflow_q     <= overflow_nxt;
            underflow_q    <= underflow_nxt;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; its contents are meaningless
        // until written, and leaving it unreset lets it map onto RAM.
        if (wr_acc) mem[wr_ptr] <= data_in;
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue presented continuously; forced to zero while empty
            // so the reset value is defined even though the array is not reset.
            always_comb begin
                data_out = empty_q ? '0 : mem[rd_ptr];
            end
        end else begin : g_std
            logic [DATA_W-1:0] dout_q;

            // Registered read: load on an accepted pop, otherwise hold
            // (including on a rejected read and on a flush).
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: one standard-mode and one FWFT
// instance share all inputs; a queue-based reference model predicts outputs.

module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          wr  = 1'b0;
    logic          rd  = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] dout_s, dout_f;
    logic          full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
    logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [CW-1:0] cnt_s, cnt_f;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .data_in(din), .rd(rd),
        .data_out(dout_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .count(cnt_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .data_in(din), .rd(rd),
        .data_out(dout_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(cnt_f),
        .overflow(ovf_f), .underflow(unf_f)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_ovf  = 1'b0;
    logic          m_unf  = 1'b0;

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic r, input logic c,
                              input logic [DW-1:0] d);
        int  n;
        bit  rd_ok, wr_ok;
        n = mq.size();
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            rd_ok = r && (n > 0);
            wr_ok = w && ((n < DEPTH) || rd_ok);
            m_ovf = w && (n == DEPTH) && !r;
            m_unf = r && (n == 0);
            if (rd_ok) m_dout = mq.pop_front();
            if (wr_ok) mq.push_back(d);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        int n;
        n = mq.size();
        check("count",        32'(cnt_s),  32'(n));
        check("empty",        32'(empty_s), 32'(n == 0));
        check("full",         32'(full_s),  32'(n == DEPTH));
        check("almost_full",  32'(af_s),    32'(n >= AF));
        check("almost_empty", 32'(ae_s),    32'(n <= AE));
        check("overflow",     32'(ovf_s),   32'(m_ovf));
        check("underflow",    32'(unf_s),   32'(m_unf));
        check("data_out_std", 32'(dout_s),  32'(m_dout));
        check("fwft_count",   32'(cnt_f),   32'(n));
        check("fwft_empty",   32'(empty_f), 32'(n == 0));
        check("fwft_ovf",     32'(ovf_f),   32'(m_ovf));
        check("fwft_unf",     32'(unf_f),   32'(m_unf));
        if (n != 0) check("data_out_fwft", 32'(dout_f), 32'(mq[0]));
    endtask

    // One clock: drive, let the edge happen, sample 1 time unit later.
    task automatic cycle(input logic w, input logic r, input logic c,
                         input logic [DW-1:0] d);
        wr = w; rd = r; clr = c; din = d;
        @(posedge clk);
        model_step(w, r, c, d);
        #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
        compare_model();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        int            cnt;
        logic          full;
        logic          af;
        logic          ovf;
        logic          unf;
        logic [DW-1:0] dout;
    } vec_t;

    localparam int NVEC = 34;
    vec_t vecs[NVEC];

    task automatic fill_table();
        // 17 writes of 0x00..0x10: the 17th hits a full FIFO
        for (int i = 0; i < 17; i++) begin
            vecs[i].wr   = 1'b1;
            vecs[i].rd   = 1'b0;
            vecs[i].din  = 8'(i);
            vecs[i].cnt  = (i < 16) ? i + 1 : 16;
            vecs[i].full = (i >= 15);
            vecs[i].af   = (i >= 13);
            vecs[i].ovf  = (i == 16);
            vecs[i].unf  = 1'b0;
            vecs[i].dout = 8'h00;
        end
        // 17 reads: 0x00..0x0F in order, then an underflow that holds 0x0F
        for (int j = 0; j < 17; j++) begin
            vecs[17+j].wr   = 1'b0;
            vecs[17+j].rd   = 1'b1;
            vecs[17+j].din  = 8'h00;
            vecs[17+j].cnt  = (j < 16) ? 15 - j : 0;
            vecs[17+j].full = 1'b0;
            vecs[17+j].af   = ((15 - j) >= AF) && (j < 16);
            vecs[17+j].ovf  = 1'b0;
            vecs[17+j].unf  = (j == 16);
            vecs[17+j].dout = (j < 16) ? 8'(j) : 8'h0F;
        end
    endtask

    // Global time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary line");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] d;
        int            pw, pr;

        fill_table();

        // ---- reset held for 2 cycles, then 3 idle cycles ----
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model();
        check("rst_count", 32'(cnt_s), 32'd0);
        check("rst_dout",  32'(dout_s), 32'h00);
        rst = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("idle_empty", 32'(empty_s), 32'd1);
        check("idle_ae",    32'(ae_s),    32'd1);

        // ---- fill / drain table ----
        for (int k = 0; k < NVEC; k++) begin
            cycle(vecs[k].wr, vecs[k].rd, 1'b0, vecs[k].din);
            check($sformatf("vec%0d_count", k), 32'(cnt_s),  32'(vecs[k].cnt));
            check($sformatf("vec%0d_full",  k), 32'(full_s), 32'(vecs[k].full));
            check($sformatf("vec%0d_af",    k), 32'(af_s),   32'(vecs[k].af));
            check($sformatf("vec%0d_ovf",   k), 32'(ovf_s),  32'(vecs[k].ovf));
            check($sformatf("vec%0d_unf",   k), 32'(unf_s),  32'(vecs[k].unf));
            check($sformatf("vec%0d_dout",  k), 32'(dout_s), 32'(vecs[k].dout));
        end

        // ---- simultaneous wr+rd at full ----
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        cycle(1'b1, 1'b1, 1'b0, 8'hAA);
        check("full_wrrd_count", 32'(cnt_s), 32'd16);
        check("full_wrrd_ovf",   32'(ovf_s), 32'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("full_wrrd_aa_last", 32'(dout_s), 32'hAA);

        // ---- simultaneous wr+rd at empty ----
        cycle(1'b1, 1'b1, 1'b0, 8'h77);
        check("empty_wrrd_count", 32'(cnt_s), 32'd1);
        check("empty_wrrd_unf",   32'(unf_s), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("empty_wrrd_data",  32'(dout_s), 32'h77);

        // ---- wrap-around at occupancy 3 ----
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'($urandom));
            check("wrap_count", 32'(cnt_s), 32'd3);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // ---- FWFT: first word falls through ----
        cycle(1'b1, 1'b0, 1'b0, 8'h5C);
        check("fwft_first_data",  32'(dout_f),  32'h5C);
        check("fwft_first_empty", 32'(empty_f), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("fwft_pop_empty",   32'(empty_f), 32'd1);

        // ---- clr at count 9 with wr ----
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h90 + i));
        check("pre_clr_count", 32'(cnt_s), 32'd9);
        cycle(1'b1, 1'b0, 1'b1, 8'hEE);
        check("clr_count", 32'(cnt_s), 32'd0);
        check("clr_empty", 32'(empty_s), 32'd1);
        check("clr_ovf",   32'(ovf_s), 32'd0);
        check("clr_dout_hold", 32'(dout_s), 32'h5C);
        cycle(1'b1, 1'b0, 1'b0, 8'h3C);
        check("post_clr_fwft", 32'(dout_f), 32'h3C);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("post_clr_std",  32'(dout_s), 32'h3C);

        // ---- randomized traffic against the model ----
        pw = 50; pr = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(2))
                    0: begin pw = 80; pr = 30; end
                    1: begin pw = 30; pr = 80; end
                    default: begin pw = 60; pr = 60; end
                endcase
            end
            d = 8'($urandom);
            cycle(($urandom_range(99) < 32'(pw)), ($urandom_range(99) < 32'(pr)),
                  ($urandom_range(149) == 0), d);
        end

        // ---- asynchronous reset mid-burst ----
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        wr = 1'b1; din = 8'h11;
        rst = 1'b0;
        #2;
        model_reset();
        check("async_rst_count", 32'(cnt_s),   32'd0);
        check("async_rst_empty", 32'(empty_s), 32'd1);
        check("async_rst_ae",    32'(ae_s),    32'd1);
        check("async_rst_af",    32'(af_s),    32'd0);
        check("async_rst_dout",  32'(dout_s),  32'h00);
        wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        compare_model();
        cycle(1'b1, 1'b0, 1'b0, 8'hC3);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        check("post_rst_data", 32'(dout_s), 32'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO; next generation of the team's fixed 8-bit FIFO.
- Adds configurable width and depth, programmable almost-full/almost-empty thresholds, and an occupancy count.
- Adds sticky-free overflow/underflow pulses, a synchronous flush, and an optional first-word-fall-through (FWFT) read mode.
- Sits between a single-clock producer and consumer; drop-in for the existing FIFO interface, with additional status outputs.

Parameters:
- DATA_W, 8: data word width in bits.
- DEPTH, 16: number of entries; power of 2, >= 4.
- AF_LEVEL, DEPTH-2: almost_full asserted when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserted when count <= AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush; highest priority after reset.
- wr  in  1  write request.
- data_in  in  DATA_W  write data.
- rd  in  1  read request / pop.
- data_out  out  DATA_W  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst=0, async assert, sync release):
  - Pointers and count = 0; data_out = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0.
  - Memory contents not reset.
- Reset mid-operation: all state returns to reset values immediately; data in flight is discarded.
- Storage: DEPTH x DATA_W array.
  - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
  - Count is tracked separately; the pointers alone never decide full/empty.
- Accept rules, evaluated on the current registered flags:
  - Write accepted iff wr && (!full || rd_accepted).
  - Read accepted iff rd && !empty.
  - Full with wr=1 and rd=1: both accepted, count unchanged, pointers both advance.
  - Empty with wr=1 and rd=1: write accepted, read rejected, underflow pulses, count -> 1.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags: registered, computed from next-state count; valid the cycle after the causing edge. No combinational path from wr/rd to any flag.
- overflow = wr && full && !rd, registered one-cycle pulse. underflow = rd && empty, registered one-cycle pulse. Neither is sticky.
- Standard mode (FWFT=0):
  - On an accepted read, data_out <= mem[rd_ptr]; visible the cycle after the rd edge.
  - data_out holds its value when no read is accepted, including on a rejected read.
- FWFT mode (FWFT=1):
  - data_out continuously presents mem[rd_ptr] while empty=0; rd pops the head.
  - The first write into an empty FIFO is visible on data_out the cycle after the write edge, coincident with empty deasserting.
  - data_out while empty = 1 is don't-care; the bench must not check it.
- clr=1 on a clock edge:
  - Pointers and count -> 0; empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - wr and rd in the same cycle are ignored; no overflow/underflow pulse.
  - data_out holds its value in standard mode.
- Write-then-read of the same entry with no intervening ops returns the written data; no read-during-write hazard exists because the FIFO is single-ported per address per cycle.

Test Plan:
- Reset: rst=0 for 2 cycles -> count=0, empty=1, almost_empty=1, full=0, data_out=0; release, idle 3 cycles -> all unchanged.
- Fill/drain, DATA_W=8, DEPTH=16, FWFT=0: write 0x00..0x0F on consecutive cycles.
  - almost_full rises after the 14th write; full after the 16th; 17th write -> overflow pulse, count stays 16.
  - Read 16 -> data_out 0x00..0x0F in order, each one cycle after its rd.
  - 17th read -> underflow pulse, data_out holds 0x0F.
- Simultaneous ops:
  - At full, wr=1 with 0xAA and rd=1 -> count stays 16, no overflow, 0xAA emerges as the 16th subsequent read.
  - At empty, wr+rd -> count=1, underflow pulse.
- Wrap-around: 40 interleaved write/read pairs at occupancy 3 -> pointers wrap twice, data order intact, count constant 3.
- FWFT=1: write 0x5C into empty FIFO -> next cycle empty=0 and data_out=0x5C with no rd; rd pops, empty=1 next cycle.
- clr and mid-op reset:
  - At count=9, clr=1 with wr=1 -> count=0, empty=1, no overflow; a subsequent write/read returns the new data.
  - rst=0 asynchronously mid-burst -> flags drop to reset values before the next clk edge.
